idp_decoder_11: RTL and testbench

//  Receive-side decoder for the 11-bit IDP/FNS crosstalk-avoidance codeword; inverse of the 11-bit IDP encoder.

---
 rtl/idp_decoder_11.sv | 118 +++++++++++
 tb/tb_idp_decoder_11.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idp_decoder_11.sv
// Two-stage receive decoder: 11-bit IDP/FNS codeword -> DW-bit integer, flags illegal top nibbles.
// Latency 2 cycles, 1 word/cycle; code_ready is combinational from data_ready (no skid buffer).
module idp_decoder_11 #(
  parameter int DW   = 8,
  parameter int ERRW = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [10:0]     codein,
  input  logic            code_valid,
  output logic            code_ready,
  output logic [DW-1:0]   dataout,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            err_nibble,
  output logic [ERRW-1:0] err_count
);
  localparam int SW    = DW + 1;
  localparam int FNS08 = 21;
  localparam int FNS10 = 55;
  localparam int FNS11 = 89;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_acc;
  logic            w_ill;
  logic [SW-1:0]   w_off;
  logic [SW-1:0]   w_hi;
  logic [SW-1:0]   w_sum;

  logic            r_s1_v;
  logic            r_s1_err;
  logic [SW-1:0]   r_s1_off;
  logic [SW-1:0]   r_s1_hi;
  logic [3:0]      r_s1_lo;
  logic            r_s2_v;
  logic            r_s2_err;
  logic [DW-1:0]   r_dataout;
  logic [ERRW-1:0] r_err_count;

  assign w_s2_adv   = !r_s2_v || data_ready;
  assign w_s1_adv   = !r_s1_v || w_s2_adv;
  assign code_ready = w_s1_adv;
  assign w_acc      = code_valid && w_s1_adv;

  assign dataout    = r_dataout;
  assign data_valid = r_s2_v;
  assign err_nibble = r_s2_err;
  assign err_count  = r_err_count;

  // Only ten top nibbles are produced by the encoder; the rest flag an error.
  always_comb begin
    w_ill = 1'b0;
    w_off = '0;
    case (codein[10:7])
      4'b0000: w_off = '0;
      4'b0001: w_off = SW'(FNS08);
      4'b1000: w_off = SW'(FNS10);
      4'b1001: w_off = SW'(FNS08 + FNS10);
      4'b0011: w_off = SW'(FNS08 + FNS11);
      4'b1100: w_off = SW'(FNS10 + FNS11);
      4'b0110: w_off = SW'(2 * FNS11);
      4'b0111: w_off = SW'(2 * FNS11 + FNS08);
      4'b1110: w_off = SW'(2 * FNS11 + FNS10);
      4'b1111: w_off = SW'(2 * FNS11 + FNS10 + FNS08);
      default: w_ill = 1'b1;
    endcase
  end

  assign w_hi  = (codein[4] ? SW'(5)  : '0)
               + (codein[5] ? SW'(8)  : '0)
               + (codein[6] ? SW'(13) : '0);

  assign w_sum = r_s1_off + r_s1_hi
               + SW'(r_s1_lo[0]) + SW'(r_s1_lo[1])
               + (r_s1_lo[2] ? SW'(2) : '0)
               + (r_s1_lo[3] ? SW'(3) : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_v   <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_off <= '0;
      r_s1_hi  <= '0;
      r_s1_lo  <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_err <= w_ill;
        r_s1_off <= w_off;
        r_s1_hi  <= w_hi;
        r_s1_lo  <= codein[3:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s2_v    <= 1'b0;
      r_s2_err  <= 1'b0;
      r_dataout <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_err  <= r_s1_err;
        r_dataout <= r_s1_err ? '0 : w_sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (r_s2_v && data_ready && r_s2_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRW'(1);
    end
  end
endmodule

// File: tb/tb_idp_decoder_11.sv
// Bench for idp_decoder_11: directed cases plus randomized traffic against a queue-based decode model.
module tb_idp_decoder_11;
  localparam int DW     = 8;
  localparam int TB_ERRW = 10;
  localparam int ECMAX  = (1 << TB_ERRW) - 1;

  logic               clock;
  logic               reset;
  logic [10:0]        codein;
  logic               code_valid;
  logic               code_ready;
  logic [DW-1:0]      dataout;
  logic               data_valid;
  logic               data_ready;
  logic               err_nibble;
  logic [TB_ERRW-1:0] err_count;

  idp_decoder_11 #(.DW(DW), .ERRW(TB_ERRW)) dut (
    .clock(clock), .reset(reset), .codein(codein), .code_valid(code_valid),
    .code_ready(code_ready), .dataout(dataout), .data_valid(data_valid),
    .data_ready(data_ready), .err_nibble(err_nibble), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;
  int qd[$];
  int qe[$];
  int xq[$];
  int mcnt = 0;
  bit exh = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode straight from the Fibonacci weights and nibble table.
  function automatic void model(input logic [10:0] c, output int d, output int e);
    int fns[13] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    int off = 0;
    int sum = 0;
    e = 0;
    case (c[10:7])
      4'd0:  off = 0;
      4'd1:  off = fns[7];
      4'd8:  off = fns[9];
      4'd9:  off = fns[7] + fns[9];
      4'd3:  off = fns[7] + fns[10];
      4'd12: off = fns[9] + fns[10];
      4'd6:  off = 2 * fns[10];
      4'd7:  off = 2 * fns[10] + fns[7];
      4'd14: off = 2 * fns[10] + fns[9];
      4'd15: off = 2 * fns[10] + fns[9] + fns[7];
      default: e = 1;
    endcase
    for (int k = 0; k < 7; k++) if (c[k]) sum += fns[k];
    d = e ? 0 : (off + sum) % (1 << DW);
  endfunction

  // Produces some codeword that must decode to v (largest offset, then greedy low part).
  function automatic logic [10:0] enc(input int v);
    int offs[10] = '{0, 21, 55, 76, 110, 144, 178, 199, 233, 254};
    logic [3:0] nibs[10] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b0011,
                             4'b1100, 4'b0110, 4'b0111, 4'b1110, 4'b1111};
    int lw[7] = '{1, 1, 2, 3, 5, 8, 13};
    int idx = 0;
    int r;
    logic [6:0] lo = '0;
    for (int i = 0; i < 10; i++) if (offs[i] <= v) idx = i;
    r = v - offs[idx];
    for (int k = 6; k >= 0; k--) if (lw[k] <= r) begin lo[k] = 1'b1; r -= lw[k]; end
    return {nibs[idx], lo};
  endfunction

  function automatic logic [10:0] illegal_code();
    logic [3:0] ill[6] = '{4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1011, 4'b1101};
    logic [6:0] lo = 7'($urandom);
    return {ill[$urandom_range(0, 5)], lo};
  endfunction

  // Monitor: scoreboard, hold-while-stalled and error-counter checks every cycle.
  initial begin
    bit held = 0;
    logic [DW-1:0] hd = '0;
    logic he = 1'b0;
    int d, e, x;
    forever begin
      @(negedge clock);
      if (reset) begin
        qd.delete(); qe.delete(); xq.delete();
        mcnt = 0;
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", data_valid, 1);
          chk("hold_data", dataout, hd);
          chk("hold_err", err_nibble, he);
        end
        chk("err_count", err_count, mcnt);
        if (data_valid && data_ready) begin
          if (qd.size() == 0) begin
            chk("spurious_output", 1, 0);
          end else begin
            d = qd.pop_front();
            e = qe.pop_front();
            chk("dataout", dataout, d);
            chk("err_nibble", err_nibble, e);
            if (exh && xq.size() > 0) begin
              x = xq.pop_front();
              chk("roundtrip", dataout, x);
            end
            if (e != 0 && mcnt != ECMAX) mcnt++;
          end
        end
        held = data_valid && !data_ready;
        hd = dataout;
        he = err_nibble;
        if (code_valid && code_ready) begin
          model(codein, d, e);
          qd.push_back(d);
          qe.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_rdy) data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the word was taken.
  task automatic send(input logic [10:0] c);
    int t = 0;
    codein = c;
    code_valid = 1'b1;
    @(negedge clock);
    while (!code_ready && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (t >= 500) chk("send_timeout", t, 0);
    @(posedge clock);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((qd.size() != 0 || data_valid) && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (t >= 2000) chk("drain_timeout", t, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    code_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    codein = '0;
    code_valid = 1'b0;
    data_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", data_valid, 0);
    chk("rst_data", dataout, 0);
    chk("rst_err", err_nibble, 0);
    chk("rst_count", err_count, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", code_ready, 1);
    @(posedge clock);
    #1;

    // zero codeword, two-cycle latency
    send(11'b0000_0000000);
    chk("t1_not_yet", data_valid, 0);
    @(posedge clock);
    #1;
    chk("t1_valid", data_valid, 1);
    chk("t1_data", dataout, 0);
    chk("t1_err", err_nibble, 0);
    @(posedge clock);
    #1;

    // back-to-back legal words
    send(11'b0001_1000000);
    send(11'b1001_1100110);
    chk("t2_w1", dataout, 34);
    send(11'b0110_0000000);
    chk("t2_w2", dataout, 100);
    @(posedge clock);
    #1;
    chk("t2_w3", dataout, 178);
    chk("t2_w3_valid", data_valid, 1);
    @(posedge clock);
    #1;
    chk("t2_idle", data_valid, 0);

    // illegal nibble
    send(11'b0010_0000001);
    @(posedge clock);
    #1;
    chk("t3_valid", data_valid, 1);
    chk("t3_err", err_nibble, 1);
    chk("t3_data", dataout, 0);
    chk("t3_cnt_before", err_count, 0);
    @(posedge clock);
    #1;
    chk("t3_cnt_after", err_count, 1);

    // backpressure: third word blocked, 257 truncates to 1
    data_ready = 1'b0;
    send(11'b0001_0000001);
    send(11'b1000_0000100);
    codein = 11'b1111_0001000;
    code_valid = 1'b1;
    repeat (5) begin
      @(posedge clock);
      #1;
      chk("t4_ready_low", code_ready, 0);
      chk("t4_hold", dataout, 22);
    end
    data_ready = 1'b1;
    #1;
    chk("t4_ready_back", code_ready, 1);
    @(posedge clock);
    #1;
    code_valid = 1'b0;
    chk("t4_w2", dataout, 57);
    @(posedge clock);
    #1;
    chk("t4_w3_wrap", dataout, 1);
    @(posedge clock);
    #1;

    // async reset with both stages full
    data_ready = 1'b0;
    send(11'b0001_0000010);
    send(11'b1000_0000010);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", data_valid, 0);
    chk("t5_count", err_count, 0);
    chk("t5_data", dataout, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("t5_ready", code_ready, 1);
    data_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("t5_dropped", data_valid, 0);
    end

    // every encodable value round-trips
    do_reset();
    exh = 1;
    for (int v = 0; v < (1 << DW); v++) begin
      xq.push_back(v);
      send(enc(v));
    end
    drain();
    exh = 0;
    chk("t6_xq_empty", xq.size(), 0);
    chk("t6_no_errors", err_count, 0);

    // randomized traffic with random backpressure
    rnd_rdy = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end else if ($urandom_range(0, 1) == 0) begin
        send(enc($urandom_range(0, (1 << DW) - 1)));
      end else begin
        send(11'($urandom));
      end
    end
    rnd_rdy = 0;
    data_ready = 1'b1;
    drain();

    // counter saturation
    for (int i = 0; i < ECMAX + 4; i++) send(illegal_code());
    drain();
    chk("t6_saturated", err_count, ECMAX);
    send(illegal_code());
    drain();
    chk("t6_stays_sat", err_count, ECMAX);

    chk("final_q_empty", qd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
